// File: rtl/uc_movimenta_asteroides_tiros.sv
// Control unit that sweeps asteroid and shot slots once per pass, issuing move/erase strobes.
// Define COLISAO_TIRO_EN to build the shot-versus-asteroid collision scan (compara/destroi).
module uc_movimenta_asteroides_tiros #(
  parameter int N_AST  = 16,
  parameter int N_TIRO = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inicia_movimentacao,
  input  logic       vidas,
  input  logic       asteroide_valido,
  input  logic       tiro_valido,
  input  logic       colisao_nave,
  input  logic       colisao_tiro,
  output logic [3:0] addr_asteroide,
  output logic [2:0] addr_tiro,
  output logic       move_asteroide,
  output logic       move_tiro,
  output logic       apaga_asteroide,
  output logic       apaga_tiro,
  output logic       decrementa_vidas,
  output logic       fim_movimentacao,
  output logic [4:0] db_estado
);

  typedef enum logic [3:0] {
    st_ocioso      = 4'd0,
    st_inicio      = 4'd1,
    st_le_ast      = 4'd2,
    st_move_ast    = 4'd3,
    st_checa_nave  = 4'd4,
    st_colide_nave = 4'd5,
    st_prox_ast    = 4'd6,
    st_le_tiro     = 4'd7,
    st_move_tiro   = 4'd8,
`ifdef COLISAO_TIRO_EN
    st_compara     = 4'd9,
    st_destroi     = 4'd10,
`endif
    st_prox_tiro   = 4'd11,
    st_concluido   = 4'd12
  } estado_t;

  estado_t estado, estado_prox;
  logic    ultimo_ast, ultimo_tiro;

  assign ultimo_ast  = (addr_asteroide == 4'(N_AST - 1));
  assign ultimo_tiro = (addr_tiro == 3'(N_TIRO - 1));

`ifndef COLISAO_TIRO_EN
  logic colisao_tiro_unused;
  assign colisao_tiro_unused = colisao_tiro;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= st_ocioso;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      st_ocioso:      if (inicia_movimentacao) estado_prox = st_inicio;
      st_inicio:      estado_prox = vidas ? st_le_ast : st_concluido;
      st_le_ast:      estado_prox = asteroide_valido ? st_move_ast : st_prox_ast;
      st_move_ast:    estado_prox = st_checa_nave;
      st_checa_nave:  estado_prox = colisao_nave ? st_colide_nave : st_prox_ast;
      st_colide_nave: estado_prox = st_prox_ast;
      st_prox_ast:    estado_prox = ultimo_ast ? st_le_tiro : st_le_ast;
      st_le_tiro:     estado_prox = tiro_valido ? st_move_tiro : st_prox_tiro;
`ifdef COLISAO_TIRO_EN
      st_move_tiro:   estado_prox = st_compara;
      st_compara: begin
        if (colisao_tiro)    estado_prox = st_destroi;
        else if (ultimo_ast) estado_prox = st_prox_tiro;
      end
      st_destroi:     estado_prox = st_prox_tiro;
`else
      st_move_tiro:   estado_prox = st_prox_tiro;
`endif
      st_prox_tiro:   estado_prox = ultimo_tiro ? st_concluido : st_le_tiro;
      st_concluido:   if (inicia_movimentacao) estado_prox = st_inicio;
      default:        estado_prox = st_ocioso;
    endcase
  end

  // Slot indices advance on leaving the prox_* states; compara walks the asteroid index in place.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_asteroide <= 4'd0;
      addr_tiro      <= 3'd0;
    end else begin
      case (estado)
        st_inicio: begin
          addr_asteroide <= 4'd0;
          addr_tiro      <= 3'd0;
        end
        st_prox_ast: addr_asteroide <= ultimo_ast ? 4'd0 : addr_asteroide + 4'd1;
`ifdef COLISAO_TIRO_EN
        st_compara: if (!colisao_tiro && !ultimo_ast) addr_asteroide <= addr_asteroide + 4'd1;
`endif
        st_prox_tiro: begin
          addr_asteroide <= 4'd0;
          if (!ultimo_tiro) addr_tiro <= addr_tiro + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    move_asteroide   = (estado == st_move_ast);
    move_tiro        = (estado == st_move_tiro);
    decrementa_vidas = (estado == st_colide_nave);
    fim_movimentacao = (estado == st_concluido);
`ifdef COLISAO_TIRO_EN
    apaga_tiro       = (estado == st_destroi);
    apaga_asteroide  = (estado == st_colide_nave) || (estado == st_destroi);
`else
    apaga_tiro       = 1'b0;
    apaga_asteroide  = (estado == st_colide_nave);
`endif
    case (estado)
      st_ocioso, st_inicio, st_le_ast, st_move_ast, st_checa_nave, st_colide_nave,
      st_prox_ast, st_le_tiro, st_move_tiro,
`ifdef COLISAO_TIRO_EN
      st_compara, st_destroi,
`endif
      st_prox_tiro, st_concluido: db_estado = {1'b0, estado};
      default:                    db_estado = 5'h0F;
    endcase
  end

endmodule

// File: tb/tb_uc_movimenta_asteroides_tiros.sv
// Directed bench for uc_movimenta_asteroides_tiros: a short table walk plus full-pass sequences
// driven by a small slot-memory model.
module tb_uc_movimenta_asteroides_tiros;

  logic       clock = 1'b0;
  logic       reset, inicia_movimentacao, vidas;
  logic       asteroide_valido, tiro_valido, colisao_nave, colisao_tiro;
  logic [3:0] addr_asteroide;
  logic [2:0] addr_tiro;
  logic       move_asteroide, move_tiro, apaga_asteroide, apaga_tiro, decrementa_vidas;
  logic       fim_movimentacao;
  logic [4:0] db_estado;

  int checks   = 0;
  int failures = 0;

  // Either direct-driven inputs (table phase) or a slot-memory model (full passes).
  logic        modo_mem;
  logic        av_d, tv_d, cn_d, ct_d;
  logic [15:0] ast_v;
  logic [7:0]  tiro_v;
  logic [4:0]  nave_slot, tiro_alvo;

  assign asteroide_valido = modo_mem ? ast_v[addr_asteroide] : av_d;
  assign tiro_valido      = modo_mem ? tiro_v[addr_tiro] : tv_d;
  assign colisao_nave     = modo_mem ? ({1'b0, addr_asteroide} == nave_slot) : cn_d;
  assign colisao_tiro     = modo_mem ? ({1'b0, addr_asteroide} == tiro_alvo) : ct_d;

  uc_movimenta_asteroides_tiros dut (
    .clock               (clock),
    .reset               (reset),
    .inicia_movimentacao (inicia_movimentacao),
    .vidas               (vidas),
    .asteroide_valido    (asteroide_valido),
    .tiro_valido         (tiro_valido),
    .colisao_nave        (colisao_nave),
    .colisao_tiro        (colisao_tiro),
    .addr_asteroide      (addr_asteroide),
    .addr_tiro           (addr_tiro),
    .move_asteroide      (move_asteroide),
    .move_tiro           (move_tiro),
    .apaga_asteroide     (apaga_asteroide),
    .apaga_tiro          (apaga_tiro),
    .decrementa_vidas    (decrementa_vidas),
    .fim_movimentacao    (fim_movimentacao),
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  // {move_asteroide, move_tiro, apaga_asteroide, apaga_tiro, decrementa_vidas, fim_movimentacao}
  function automatic logic [5:0] saidas();
    return {move_asteroide, move_tiro, apaga_asteroide, apaga_tiro, decrementa_vidas, fim_movimentacao};
  endfunction

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inicia_movimentacao = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  int n_ciclos, n_dec, n_apa, n_apt, n_mva, n_mvt;
  logic [3:0] aa_dec, aa_apt;
  logic [2:0] at_apt;
  logic       apa_com_apt;

  task automatic run_pass(input int budget);
    n_ciclos = 0; n_dec = 0; n_apa = 0; n_apt = 0; n_mva = 0; n_mvt = 0;
    aa_dec = 4'hF; aa_apt = 4'hF; at_apt = 3'h7; apa_com_apt = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      step();
      n_ciclos = i;
      if (decrementa_vidas) begin n_dec++; aa_dec = addr_asteroide; end
      if (apaga_asteroide) n_apa++;
      if (move_asteroide) n_mva++;
      if (move_tiro) n_mvt++;
      if (apaga_tiro) begin
        n_apt++; aa_apt = addr_asteroide; at_apt = addr_tiro; apa_com_apt = apaga_asteroide;
      end
      if (fim_movimentacao) break;
    end
  endtask

  typedef struct packed {
    logic       inicia, vid, av, tv, cn, ct;
    logic [4:0] estado;
    logic [3:0] aa;
    logic [2:0] at;
    logic [5:0] sv;
  } vec_t;

  vec_t tab [13];

  initial begin
    reset = 1'b1; inicia_movimentacao = 1'b0; vidas = 1'b1;
    modo_mem = 1'b0; av_d = 1'b0; tv_d = 1'b0; cn_d = 1'b0; ct_d = 1'b0;
    ast_v = '0; tiro_v = '0; nave_slot = 5'h1F; tiro_alvo = 5'h1F;

    tab[0]  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 3'd0, 6'b000000};
    tab[1]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 4'd0, 3'd0, 6'b000000};
    tab[2]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 4'd0, 3'd0, 6'b000000};
    tab[3]  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 4'd0, 3'd0, 6'b100000};
    tab[4]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 4'd0, 3'd0, 6'b000000};
    tab[5]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 4'd0, 3'd0, 6'b001010};
    tab[6]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 4'd0, 3'd0, 6'b000000};
    tab[7]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 4'd1, 3'd0, 6'b000000};
    tab[8]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 4'd1, 3'd0, 6'b000000};
    tab[9]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 4'd2, 3'd0, 6'b000000};
    tab[10] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 4'd2, 3'd0, 6'b100000};
    tab[11] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 4'd2, 3'd0, 6'b000000};
    tab[12] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 4'd2, 3'd0, 6'b000000};

    do_reset();
    chk("reset_estado", 32'(db_estado), 32'd0);
    chk("reset_saidas", 32'(saidas()), 32'd0);
    chk("reset_addr", 32'({addr_asteroide, addr_tiro}), 32'd0);

    // Table walk through the first asteroid slots.
    for (int k = 0; k < 13; k++) begin
      inicia_movimentacao = tab[k].inicia;
      vidas = tab[k].vid;
      av_d = tab[k].av; tv_d = tab[k].tv; cn_d = tab[k].cn; ct_d = tab[k].ct;
      step();
      chk($sformatf("tab%0d_estado", k), 32'(db_estado), 32'(tab[k].estado));
      chk($sformatf("tab%0d_addr_ast", k), 32'(addr_asteroide), 32'(tab[k].aa));
      chk($sformatf("tab%0d_addr_tiro", k), 32'(addr_tiro), 32'(tab[k].at));
      chk($sformatf("tab%0d_saidas", k), 32'(saidas()), 32'(tab[k].sv));
    end
    av_d = 1'b0; cn_d = 1'b0;

    // Empty pass: concluido reached at cycle 50, then back-to-back restart.
    modo_mem = 1'b1;
    do_reset();
    vidas = 1'b1;
    inicia_movimentacao = 1'b1;
    run_pass(200);
    chk("vazio_ciclos", 32'(n_ciclos), 32'd50);
    chk("vazio_fim", 32'(fim_movimentacao), 32'd1);
    chk("vazio_estado", 32'(db_estado), 32'd12);
    chk("vazio_strobes", 32'(n_dec + n_apa + n_apt + n_mva + n_mvt), 32'd0);
    step();
    chk("b2b_estado", 32'(db_estado), 32'd1);
    chk("b2b_fim", 32'(fim_movimentacao), 32'd0);

    // Asteroid 3 hits the ship.
    do_reset();
    ast_v = 16'h0008; nave_slot = 5'd3;
    inicia_movimentacao = 1'b1;
    run_pass(200);
    chk("nave_ciclos", 32'(n_ciclos), 32'd53);
    chk("nave_dec", 32'(n_dec), 32'd1);
    chk("nave_apaga_ast", 32'(n_apa), 32'd1);
    chk("nave_addr", 32'(aa_dec), 32'd3);
    chk("nave_move_ast", 32'(n_mva), 32'd1);
    ast_v = '0; nave_slot = 5'h1F;

    // Shot 2 hits asteroid 5.
    do_reset();
    tiro_v = 8'h04; tiro_alvo = 5'd5;
    inicia_movimentacao = 1'b1;
    run_pass(500);
    chk("tiro_fim", 32'(fim_movimentacao), 32'd1);
    chk("tiro_move", 32'(n_mvt), 32'd1);
`ifdef COLISAO_TIRO_EN
    chk("tiro_apaga_tiro", 32'(n_apt), 32'd1);
    chk("tiro_apaga_ast", 32'(n_apa), 32'd1);
    chk("tiro_juntos", 32'(apa_com_apt), 32'd1);
    chk("tiro_addr_tiro", 32'(at_apt), 32'd2);
    chk("tiro_addr_ast", 32'(aa_apt), 32'd5);
`else
    chk("tiro_apaga_tiro", 32'(n_apt), 32'd0);
    chk("tiro_apaga_ast", 32'(n_apa), 32'd0);
    chk("tiro_ciclos", 32'(n_ciclos), 32'd51);
`endif
    tiro_v = '0; tiro_alvo = 5'h1F;

    // No lives left: straight to concluido.
    do_reset();
    vidas = 1'b0;
    inicia_movimentacao = 1'b1;
    step();
    chk("semvida_c1_estado", 32'(db_estado), 32'd1);
    chk("semvida_c1_saidas", 32'(saidas()), 32'd0);
    step();
    chk("semvida_c2_estado", 32'(db_estado), 32'd12);
    chk("semvida_c2_saidas", 32'(saidas()), 32'b000001);
    vidas = 1'b1;

    // Request dropped mid-pass.
    do_reset();
    inicia_movimentacao = 1'b1;
    repeat (10) step();
    inicia_movimentacao = 1'b0;
    run_pass(200);
    chk("queda_ciclos", 32'(n_ciclos), 32'd40);
    chk("queda_fim", 32'(fim_movimentacao), 32'd1);
    begin
      int segura = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (fim_movimentacao && db_estado == 5'd12) segura++;
      end
      chk("queda_segura", 32'(segura), 32'd5);
    end
    inicia_movimentacao = 1'b1;
    step();
    chk("queda_reinicia", 32'(db_estado), 32'd1);
    chk("queda_fim0", 32'(fim_movimentacao), 32'd0);

    // Reset while in move_tiro for shot 3.
    do_reset();
    tiro_v = 8'h08;
    inicia_movimentacao = 1'b1;
    begin
      int achou = 0;
      for (int i = 0; i < 200; i++) begin
        step();
        if (db_estado == 5'd8) begin achou = 1; break; end
      end
      chk("rst_chegou_move_tiro", 32'(achou), 32'd1);
      chk("rst_pre_addr_tiro", 32'(addr_tiro), 32'd3);
    end
    reset = 1'b1;
    step();
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_saidas", 32'(saidas()), 32'd0);
    chk("rst_addr", 32'({addr_asteroide, addr_tiro}), 32'd0);
    reset = 1'b0;
    inicia_movimentacao = 1'b0;
    tiro_v = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
